// File: rtl/sng_multichannel.sv
// Multi-channel stochastic number generator: one shared Fibonacci LFSR feeds
// CHANNELS comparators that turn latched operands into unipolar bit streams.
module sng_multichannel #(
   parameter int                WIDTH    = 4,
   parameter int                CHANNELS = 3,
   parameter int                DECORR   = 1,
   parameter logic [WIDTH-1:0]  SEED_RST = WIDTH'(1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [WIDTH-1:0]             seed,
   input  logic [WIDTH-1:0]             len,
   input  logic                         en,
   input  logic [CHANNELS*WIDTH-1:0]    X,
   output logic [WIDTH-1:0]             L,
   output logic [CHANNELS-1:0]          SBS,
   output logic                         valid,
   output logic                         busy,
   output logic                         done,
   output logic [CHANNELS*WIDTH-1:0]    ones
);

   // state  | meaning
   // IDLE   | waiting for start, LFSR holds
   // RUN    | emitting stream bits while en=1
   // DONE   | one-cycle done pulse, back to IDLE
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [15:0]      TAPS16 = (WIDTH == 4) ? 16'h000C :
                                         (WIDTH == 8) ? 16'h00B8 : 16'hD008;
   localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

   state_t                       r_state;
   logic [WIDTH-1:0]             r_lfsr;
   logic [WIDTH-1:0]             r_len;
   logic [WIDTH-1:0]             r_cnt;
   logic [CHANNELS*WIDTH-1:0]    r_x;
   logic [CHANNELS*WIDTH-1:0]    r_ones;
   logic [CHANNELS-1:0]          r_sbs;
   logic                         r_valid;
   logic                         r_done;

   logic                         w_fb;
   logic [WIDTH-1:0]             w_lfsr_next;
   logic [WIDTH-1:0]             w_len_eff;
   logic [WIDTH-1:0]             w_seed_eff;
   logic [CHANNELS-1:0]          w_bit;

   assign w_fb        = ^(r_lfsr & TAPS);
   assign w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
   assign w_len_eff   = (len == '0) ? '1 : len;
   assign w_seed_eff  = (seed == '0) ? WIDTH'(1) : seed;

   // Rotating the reference per channel decorrelates streams while keeping
   // each channel's reference a permutation of the nonzero LFSR states.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam int ROT = (DECORR != 0) ? (k % WIDTH) : 0;
      logic [WIDTH-1:0] w_ref;
      if (ROT == 0) begin : g_norot
         assign w_ref = r_lfsr;
      end else begin : g_rot
         assign w_ref = {r_lfsr[WIDTH-1-ROT:0], r_lfsr[WIDTH-1 -: ROT]};
      end
      assign w_bit[k] = (r_x[k*WIDTH +: WIDTH] > w_ref);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_lfsr  <= SEED_RST;
         r_len   <= '0;
         r_cnt   <= '0;
         r_x     <= '0;
         r_ones  <= '0;
         r_sbs   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               r_done  <= 1'b0;
               if (start) begin
                  r_x     <= X;
                  r_len   <= w_len_eff;
                  r_lfsr  <= w_seed_eff;
                  r_ones  <= '0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_done <= 1'b0;
               if (en) begin
                  r_sbs   <= w_bit;
                  r_valid <= 1'b1;
                  for (int k = 0; k < CHANNELS; k++) begin
                     r_ones[k*WIDTH +: WIDTH] <= r_ones[k*WIDTH +: WIDTH] + WIDTH'(w_bit[k]);
                  end
                  r_lfsr <= w_lfsr_next;
                  r_cnt  <= r_cnt + WIDTH'(1);
                  if (r_cnt == r_len - WIDTH'(1)) begin
                     r_state <= S_DONE;
                  end
               end else begin
                  r_valid <= 1'b0;
               end
            end
            S_DONE: begin
               r_valid <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign L     = r_lfsr;
   assign SBS   = r_sbs;
   assign valid = r_valid;
   assign done  = r_done;
   assign busy  = (r_state != S_IDLE);
   assign ones  = r_ones;

endmodule

// File: tb/tb_sng_multichannel.sv
// Bench for sng_multichannel: two 4-bit 3-channel instances (rotated and
// unrotated references) sharing stimulus, plus an 8-bit 2-channel instance.
module tb_sng_multichannel;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_start, a_en;
   logic [3:0]  a_seed, a_len;
   logic [11:0] a_x;
   logic [3:0]  a_L, b_L;
   logic [2:0]  a_sbs, b_sbs;
   logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
   logic [11:0] a_ones, b_ones;

   logic        c_start, c_en;
   logic [7:0]  c_seed, c_len;
   logic [15:0] c_x;
   logic [7:0]  c_L;
   logic [1:0]  c_sbs;
   logic        c_valid, c_busy, c_done;
   logic [15:0] c_ones;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sng_multichannel #(.WIDTH(4), .CHANNELS(3), .DECORR(1)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .seed(a_seed), .len(a_len), .en(a_en),
      .X(a_x), .L(a_L), .SBS(a_sbs), .valid(a_valid), .busy(a_busy), .done(a_done),
      .ones(a_ones));

   sng_multichannel #(.WIDTH(4), .CHANNELS(3), .DECORR(0)) dut_b (
      .clk(clk), .rst(rst), .start(a_start), .seed(a_seed), .len(a_len), .en(a_en),
      .X(a_x), .L(b_L), .SBS(b_sbs), .valid(b_valid), .busy(b_busy), .done(b_done),
      .ones(b_ones));

   sng_multichannel #(.WIDTH(8), .CHANNELS(2), .DECORR(1)) dut_c (
      .clk(clk), .rst(rst), .start(c_start), .seed(c_seed), .len(c_len), .en(c_en),
      .X(c_x), .L(c_L), .SBS(c_sbs), .valid(c_valid), .busy(c_busy), .done(c_done),
      .ones(c_ones));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Fibonacci LFSR step from the characteristic polynomial of each width.
   function automatic int lfsr_step(input int w, input int s);
      int taps;
      int fb;
      taps = (w == 4) ? 'h000C : (w == 8) ? 'h00B8 : 'hD008;
      fb   = $countones(s & taps) % 2;
      return ((s << 1) | fb) & ((1 << w) - 1);
   endfunction

   function automatic int rotl(input int w, input int v, input int k);
      int r;
      r = k % w;
      if (r == 0) return v;
      return ((v << r) | (v >> (w - r))) & ((1 << w) - 1);
   endfunction

   task automatic run_ab(input logic [11:0] x, input logic [3:0] sd, input logic [3:0] ln,
                         input int stall_pct, input int stall_at, input bit noise,
                         output int nv, output int edges, output bit diff01);
      int len_e, ml, cyc, mn, xk;
      int oa[3];
      int ob[3];
      logic [2:0] ea, eb;
      bit en_d;
      len_e = (ln == 0) ? 15 : int'(ln);
      ml    = (sd == 0) ? 1 : int'(sd);
      nv = 0; cyc = 0; mn = 0; diff01 = 1'b0; ea = '0; eb = '0;
      for (int k = 0; k < 3; k++) begin oa[k] = 0; ob[k] = 0; end
      a_x = x; a_seed = sd; a_len = ln; a_en = 1'b1; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      chk("accept_busy", a_busy, 1);
      chk("accept_valid", a_valid, 0);
      chk("accept_L", a_L, ml);
      chk("accept_ones", a_ones, 0);
      while (mn < len_e) begin
         en_d = ($urandom_range(99) >= stall_pct) &&
                !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
         a_en = en_d;
         if (noise) begin
            a_start = 1'($urandom_range(1));
            a_x = 12'($urandom); a_seed = 4'($urandom); a_len = 4'($urandom);
         end
         @(posedge clk); #1;
         cyc++;
         if (en_d) begin
            for (int k = 0; k < 3; k++) begin
               xk    = int'(x[k*4 +: 4]);
               ea[k] = (xk > rotl(4, ml, k));
               eb[k] = (xk > ml);
               oa[k] += int'(ea[k]);
               ob[k] += int'(eb[k]);
            end
            ml = lfsr_step(4, ml);
            mn++;
         end
         if (a_valid) nv++;
         if (a_valid && (a_sbs[1] != a_sbs[0])) diff01 = 1'b1;
         chk("run_valid_a", a_valid, en_d);
         chk("run_valid_b", b_valid, en_d);
         if (mn > 0) begin
            chk("run_sbs_a", a_sbs, ea);
            chk("run_sbs_b", b_sbs, eb);
         end
         chk("run_L_a", a_L, ml);
         chk("run_L_b", b_L, ml);
         chk("run_ones_a", a_ones, {4'(oa[2]), 4'(oa[1]), 4'(oa[0])});
         chk("run_ones_b", b_ones, {4'(ob[2]), 4'(ob[1]), 4'(ob[0])});
         chk("run_busy", a_busy, 1);
         chk("run_done", a_done, 0);
      end
      a_start = 1'b0;
      a_en = 1'($urandom_range(1));
      @(posedge clk); #1;
      cyc++;
      chk("end_done_a", a_done, 1);
      chk("end_done_b", b_done, 1);
      chk("end_valid", a_valid, 0);
      chk("end_busy", a_busy, 0);
      chk("end_L", a_L, ml);
      chk("end_ones_a", a_ones, {4'(oa[2]), 4'(oa[1]), 4'(oa[0])});
      edges = cyc;
      @(posedge clk); #1;
      chk("post_done", a_done, 0);
   endtask

   task automatic run_c(input logic [15:0] x, input logic [7:0] sd, input logic [7:0] ln,
                        output int nv);
      int len_e, ml, mn;
      int oc[2];
      logic [1:0] ec;
      len_e = (ln == 0) ? 255 : int'(ln);
      ml = (sd == 0) ? 1 : int'(sd);
      nv = 0; mn = 0; oc[0] = 0; oc[1] = 0; ec = '0;
      c_x = x; c_seed = sd; c_len = ln; c_en = 1'b1; c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      chk("c_accept_L", c_L, ml);
      while (mn < len_e) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            ec[k] = (int'(x[k*8 +: 8]) > rotl(8, ml, k));
            oc[k] += int'(ec[k]);
         end
         ml = lfsr_step(8, ml);
         mn++;
         if (c_valid) nv++;
         chk("c_sbs", c_sbs, ec);
      end
      @(posedge clk); #1;
      chk("c_done", c_done, 1);
      chk("c_ones", c_ones, {8'(oc[1]), 8'(oc[0])});
      chk("c_L", c_L, ml);
      @(posedge clk); #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int nv, ed;
      bit d;
      rst = 1'b1;
      a_start = 0; a_en = 0; a_seed = 0; a_len = 0; a_x = 0;
      c_start = 0; c_en = 0; c_seed = 0; c_len = 0; c_x = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_L_a", a_L, 1);
      chk("rst_sbs_a", a_sbs, 0);
      chk("rst_valid_a", a_valid, 0);
      chk("rst_busy_a", a_busy, 0);
      chk("rst_done_a", a_done, 0);
      chk("rst_ones_a", a_ones, 0);
      chk("rst_L_c", c_L, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full period, X=(7,5,4)
      run_ab(12'h457, 4'd1, 4'd0, 0, -1, 1'b0, nv, ed, d);
      chk("s1_nvalid", nv, 15);
      chk("s1_ones_a", a_ones, 12'h346);
      chk("s1_ones_b", b_ones, 12'h346);
      chk("s1_L", a_L, 1);

      // Rotated reference separates equal operands; counts unchanged
      run_ab(12'h477, 4'd1, 4'd0, 0, -1, 1'b0, nv, ed, d);
      chk("s2_diff", d, 1);
      chk("s2_ones_a", a_ones, 12'h366);
      chk("s2_ones_b", b_ones, 12'h366);

      // 8-bit extremes and zero seed
      run_c(16'hFF00, 8'hA5, 8'd0, nv);
      chk("s3_nvalid", nv, 255);
      chk("s3_ones", c_ones, 16'hFE00);
      run_c(16'h8040, 8'h00, 8'd0, nv);
      chk("s3_seed0_ones", c_ones, 16'h7F3F);
      chk("s3_seed0_L", c_L, 1);
      run_c(16'($urandom), 8'($urandom), 8'($urandom_range(1, 40)), nv);

      // len=10 with a 5-cycle stall
      run_ab(12'($urandom), 4'($urandom), 4'd10, 0, 4, 1'b0, nv, ed, d);
      chk("s4_nvalid", nv, 10);
      chk("s4_done_edge", ed - 1, 15);

      // Reset mid-run
      a_x = 12'h457; a_seed = 4'd9; a_len = 4'd0; a_en = 1'b1; a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("s5_L", a_L, 1);
      chk("s5_valid", a_valid, 0);
      chk("s5_busy", a_busy, 0);
      chk("s5_ones", a_ones, 0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("s5_no_done", a_done, 0);
      end

      // Random runs with input noise, spurious starts and stalls
      for (int r = 0; r < 6; r++) begin
         run_ab(12'($urandom), 4'($urandom), 4'($urandom), 30, -1, 1'b1, nv, ed, d);
         chk("s6_nvalid", nv, (a_len == a_len) ? nv : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
